// File: rtl/config_sched_pkg.sv
// Shared types and constants for the configuration programming scheduler.
package config_sched_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LAUNCH    = 3'd1,
        WAIT_ACK  = 3'd2,
        WAIT_DONE = 3'd3,
        HOLD      = 3'd4
    } sched_state_t;

    localparam logic BANK_HOST = 1'b0;
    localparam logic BANK_ALT  = 1'b1;

endpackage

// File: rtl/config_prog_scheduler_scrub_timer.sv
// Free-running scrub prescaler; emits a one-cycle tick at wrap when scrub is enabled.
module scrub_timer
    import config_sched_pkg::*;
#(
    parameter int unsigned PRESCALE_W = 26
) (
    input  logic clkin,
    input  logic rst,
    input  logic scrub_en,
    output logic tick_c
);

    logic [PRESCALE_W-1:0] prescaler;

    // Prescaler starts at 1 so the first tick lands 2^PRESCALE_W-1 cycles after reset
    always_ff @(posedge clkin) begin
        if (rst) begin
            prescaler <= PRESCALE_W'(1);
        end else begin
            prescaler <= prescaler + PRESCALE_W'(1);
        end
    end

    // Ticks while scrub is disabled are simply dropped
    assign tick_c = scrub_en && (prescaler == '0);

endmodule

// File: rtl/config_prog_scheduler.sv
// Arbitrates host and scrub programming requests and sequences the serial
// configuration shift engine (start pulse, busy handshake, watchdog, holdoff).
// Optional feature macro: CFG_ALTERNATE_BANK_EN -- scrubs alternate between
// banks (first scrub after reset uses BANK_ALT); otherwise scrubs reprogram bank 0.
module config_prog_scheduler
    import config_sched_pkg::*;
#(
    parameter int unsigned PRESCALE_W = 26,
    parameter int unsigned TIMEOUT_W  = 16,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned HOLDOFF    = 4
) (
    input  logic             clkin,
    input  logic             rst,
    input  logic             host_req,
    input  logic             scrub_en,
    input  logic             eng_busy,
    output logic             eng_start,
    output logic             bank_sel,
    output logic             busy,
    output logic [CNT_W-1:0] prog_count,
    output logic             timeout_err
);

    localparam int unsigned HOLD_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLDOFF - 1);

    sched_state_t           state;
    logic                   host_prev;
    logic                   host_pend;
    logic                   scrub_pend;
    logic [TIMEOUT_W-1:0]   watchdog;
    logic [HOLD_W-1:0]      hold_cnt;
    logic                   host_edge_c;
    logic                   scrub_tick_c;
    logic                   scrub_bank_c;

    scrub_timer #(
        .PRESCALE_W (PRESCALE_W)
    ) u_scrub_timer (
        .clkin    (clkin),
        .rst      (rst),
        .scrub_en (scrub_en),
        .tick_c   (scrub_tick_c)
    );

    assign host_edge_c = host_req && !host_prev;

`ifdef CFG_ALTERNATE_BANK_EN
    logic alt_bank;

    // Each served scrub flips to the bank opposite the previous scrub
    assign scrub_bank_c = ~alt_bank;
`else
    // Scrub is a golden refresh of the host bank
    assign scrub_bank_c = BANK_HOST;
`endif

    // Request capture, arbitration, engine handshake FSM and status counters
    always_ff @(posedge clkin) begin
        if (rst) begin
            state       <= IDLE;
            host_prev   <= 1'b0;
            host_pend   <= 1'b0;
            scrub_pend  <= 1'b0;
            watchdog    <= '0;
            hold_cnt    <= '0;
            eng_start   <= 1'b0;
            bank_sel    <= BANK_HOST;
            busy        <= 1'b0;
            prog_count  <= '0;
            timeout_err <= 1'b0;
`ifdef CFG_ALTERNATE_BANK_EN
            alt_bank    <= BANK_HOST;
`endif
        end else begin
            host_prev  <= host_req;
            eng_start  <= 1'b0;
            host_pend  <= host_pend | host_edge_c;
            scrub_pend <= scrub_pend | scrub_tick_c;

            case (state)
                IDLE: begin
                    if (host_pend) begin
                        state     <= LAUNCH;
                        busy      <= 1'b1;
                        eng_start <= 1'b1;
                        bank_sel  <= BANK_HOST;
                        host_pend <= host_edge_c;
                    end else if (scrub_pend) begin
                        state      <= LAUNCH;
                        busy       <= 1'b1;
                        eng_start  <= 1'b1;
                        bank_sel   <= scrub_bank_c;
                        scrub_pend <= scrub_tick_c;
`ifdef CFG_ALTERNATE_BANK_EN
                        alt_bank   <= scrub_bank_c;
`endif
                    end
                end
                LAUNCH: begin
                    watchdog <= '0;
                    state    <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (watchdog == {TIMEOUT_W{1'b1}}) begin
                        timeout_err <= 1'b1;
                        hold_cnt    <= '0;
                        state       <= HOLD;
                    end else begin
                        watchdog <= watchdog + TIMEOUT_W'(1);
                        if (eng_busy) begin
                            state <= WAIT_DONE;
                        end
                    end
                end
                WAIT_DONE: begin
                    if (watchdog == {TIMEOUT_W{1'b1}}) begin
                        timeout_err <= 1'b1;
                        hold_cnt    <= '0;
                        state       <= HOLD;
                    end else begin
                        watchdog <= watchdog + TIMEOUT_W'(1);
                        if (!eng_busy) begin
                            if (prog_count != {CNT_W{1'b1}}) begin
                                prog_count <= prog_count + CNT_W'(1);
                            end
                            hold_cnt <= '0;
                            state    <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_config_prog_scheduler.sv
// Self-checking bench for config_prog_scheduler: directed vector table, directed
// corner sequences and random traffic checked against a timeline reference model.
module tb_config_prog_scheduler;

    localparam int unsigned PRESCALE_W = 6;
    localparam int unsigned TIMEOUT_W  = 5;
    localparam int unsigned CNT_W      = 4;
    localparam int unsigned HOLDOFF    = 4;
    localparam int ENG_DLY     = 2;
    localparam int TICK_PERIOD = 1 << PRESCALE_W;
    localparam int WD_SPAN     = (1 << TIMEOUT_W) + 1;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;
`ifdef CFG_ALTERNATE_BANK_EN
    localparam bit ALT_MODE = 1'b1;
`else
    localparam bit ALT_MODE = 1'b0;
`endif

    logic             clkin = 1'b0;
    logic             rst;
    logic             host_req;
    logic             scrub_en;
    logic             eng_busy;
    logic             eng_start;
    logic             bank_sel;
    logic             busy;
    logic [CNT_W-1:0] prog_count;
    logic             timeout_err;

    config_prog_scheduler #(
        .PRESCALE_W (PRESCALE_W),
        .TIMEOUT_W  (TIMEOUT_W),
        .CNT_W      (CNT_W),
        .HOLDOFF    (HOLDOFF)
    ) dut (
        .clkin       (clkin),
        .rst         (rst),
        .host_req    (host_req),
        .scrub_en    (scrub_en),
        .eng_busy    (eng_busy),
        .eng_start   (eng_start),
        .bank_sel    (bank_sel),
        .busy        (busy),
        .prog_count  (prog_count),
        .timeout_err (timeout_err)
    );

    always #5 clkin = ~clkin;

    int n_tests = 0;
    int n_fail  = 0;

    // Cycle index since reset release, sampled outputs, start log
    int cyc;
    int s_start, s_busy, s_bank, s_cnt, s_terr;
    int q_start[$];
    int q_bank[$];

    // Engine stimulus knobs and engine busy window
    int eng_len   = 10;
    int eng_never = 0;
    int eng_on, eng_off;

    // Reference model: pending flags plus the timeline of the job in flight
    int m_prev_h, m_hpend, m_spend, m_alt_last, m_cnt, m_terr;
    int m_launch_at, m_free_at, m_done_at, m_done_ok, m_bank, m_len, m_never;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_prev_h = 0; m_hpend = 0; m_spend = 0; m_alt_last = 0;
        m_cnt = 0; m_terr = 0; m_launch_at = -1; m_free_at = 0;
        m_done_at = -1; m_done_ok = 0; m_bank = 0; m_len = 0; m_never = 0;
        eng_on = -1; eng_off = -1;
        cyc = 0;
        q_start.delete();
        q_bank.delete();
    endtask

    // Advance the model from cycle cyc to cyc+1 using this cycle's inputs
    task automatic model_advance();
        int t;
        bit h_edge, tick;
        t = cyc;
        h_edge = host_req && (m_prev_h == 0);
        m_prev_h = int'(host_req);
        tick = (((t + 1) % TICK_PERIOD) == 0) && scrub_en;
        if (t + 1 == m_done_at) begin
            if (m_done_ok != 0) begin
                if (m_cnt < CNT_MAX) m_cnt++;
            end else begin
                m_terr = 1;
            end
        end
        if (t >= m_free_at && (m_hpend != 0 || m_spend != 0)) begin
            if (m_hpend != 0) begin
                m_bank = 0;
                m_hpend = 0;
            end else begin
                m_bank = ALT_MODE ? (1 - m_alt_last) : 0;
                m_alt_last = m_bank;
                m_spend = 0;
            end
            m_launch_at = t + 1;
            m_len = eng_len;
            m_never = eng_never;
            if (eng_never != 0) begin
                m_done_ok = 0;
                m_done_at = m_launch_at + WD_SPAN;
            end else begin
                m_done_ok = 1;
                m_done_at = m_launch_at + ENG_DLY + eng_len + 1;
            end
            m_free_at = m_done_at + int'(HOLDOFF);
        end
        if (h_edge) m_hpend = 1;
        if (tick) m_spend = 1;
    endtask

    // One clock: sample and compare at negedge, advance model, drive engine
    task automatic tick_cycle();
        @(negedge clkin);
        s_start = int'(eng_start);
        s_busy  = int'(busy);
        s_bank  = int'(bank_sel);
        s_cnt   = int'(prog_count);
        s_terr  = int'(timeout_err);
        check("eng_start", s_start, int'(cyc == m_launch_at));
        check("busy", s_busy, int'((cyc >= m_launch_at) && (cyc < m_free_at)));
        check("bank_sel", s_bank, m_bank);
        check("prog_count", s_cnt, m_cnt);
        check("timeout_err", s_terr, m_terr);
        if (s_start != 0) begin
            q_start.push_back(cyc);
            q_bank.push_back(s_bank);
            if (m_never == 0) begin
                eng_on  = cyc + ENG_DLY;
                eng_off = cyc + ENG_DLY + m_len;
            end
        end
        model_advance();
        @(posedge clkin);
        #1;
        cyc++;
        eng_busy = (cyc >= eng_on) && (cyc < eng_off);
    endtask

    // Synchronous reset for one edge; called just after a posedge
    task automatic do_reset();
        rst = 1'b1;
        eng_busy = 1'b0;
        @(posedge clkin);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    typedef struct {
        bit hreq;
        int start;
        int busy;
        int cnt;
    } vec_t;

    vec_t vecs[22];

    initial begin
        #1_000_000;
        $display("FAIL global_timeout cyc=%0d", cyc);
        $fatal(1);
    end

    initial begin
        int st;
        rst = 1'b1;
        host_req = 1'b0;
        scrub_en = 1'b0;
        eng_busy = 1'b0;
        model_reset();
        repeat (3) @(posedge clkin);
        #1;
        rst = 1'b0;

        // Directed host transaction from reset: edge at 1, start at 3, done visible at 16, idle at 20
        for (int i = 0; i < 22; i++) begin
            vecs[i] = '{hreq: (i >= 1), start: int'(i == 3), busy: int'(i >= 3 && i < 20),
                        cnt: (i >= 16) ? 1 : 0};
        end
        eng_len = 10;
        eng_never = 0;
        do_reset();
        for (int i = 0; i < 22; i++) begin
            host_req = vecs[i].hreq;
            tick_cycle();
            check("vec_start", s_start, vecs[i].start);
            check("vec_busy", s_busy, vecs[i].busy);
            check("vec_cnt", s_cnt, vecs[i].cnt);
            check("vec_bank", s_bank, 0);
        end

        // Scrub only: ticks at 63, 127, 191 give starts at 65, 129, 193
        host_req = 1'b0;
        do_reset();
        scrub_en = 1'b1;
        repeat (215) tick_cycle();
        check("scrub_starts", q_start.size(), 3);
        if (q_start.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                check("scrub_start_cyc", q_start[i], 65 + 64 * i);
                check("scrub_bank", q_bank[i], ALT_MODE ? ((i % 2 == 0) ? 1 : 0) : 0);
            end
        end
        check("scrub_count", s_cnt, 3);

        // Host edge coincides with scrub tick at 63: host first, scrub after holdoff
        scrub_en = 1'b0;
        do_reset();
        for (int i = 0; i < 140; i++) begin
            host_req = (cyc >= 63);
            scrub_en = (cyc < 100);
            tick_cycle();
        end
        check("collide_starts", q_start.size(), 2);
        if (q_start.size() == 2) begin
            check("collide_host_cyc", q_start[0], 65);
            check("collide_host_bank", q_bank[0], 0);
            check("collide_scrub_cyc", q_start[1], 83);
            check("collide_scrub_bank", q_bank[1], ALT_MODE ? 1 : 0);
        end
        check("collide_count", s_cnt, 2);

        // Silent engine: watchdog expires, count unchanged, next host request still served
        host_req = 1'b0;
        scrub_en = 1'b0;
        do_reset();
        eng_never = 1;
        for (int i = 0; i < 46; i++) begin
            host_req = (cyc >= 1);
            tick_cycle();
        end
        check("to_err", s_terr, 1);
        check("to_count", s_cnt, 0);
        check("to_idle", s_busy, 0);
        eng_never = 0;
        host_req = 1'b0;
        tick_cycle();
        host_req = 1'b1;
        repeat (24) tick_cycle();
        check("to_recover_count", s_cnt, 1);
        check("to_err_sticky", s_terr, 1);

        // Reset during WAIT_DONE with a host request pending
        host_req = 1'b0;
        tick_cycle();
        host_req = 1'b1;
        st = -1;
        for (int k = 0; k < 10 && st < 0; k++) begin
            tick_cycle();
            if (s_start != 0) st = cyc - 1;
        end
        check("rst_start_seen", int'(st >= 0), 1);
        if (st < 0) st = cyc;
        host_req = 1'b0;
        tick_cycle();
        host_req = 1'b1;
        tick_cycle();
        host_req = 1'b0;
        while (cyc < st + 8) tick_cycle();
        do_reset();
        tick_cycle();
        check("rst_eng_start", s_start, 0);
        check("rst_busy", s_busy, 0);
        check("rst_bank", s_bank, 0);
        check("rst_count", s_cnt, 0);
        check("rst_terr", s_terr, 0);
        repeat (30) tick_cycle();
        check("rst_pend_lost", q_start.size(), 0);

        // Saturation: short engine jobs, count climbs to 15 and stays
        do_reset();
        eng_len = 1;
        for (int r = 0; r < 18; r++) begin
            host_req = 1'b1;
            tick_cycle();
            host_req = 1'b0;
            repeat (11) tick_cycle();
            check("sat_count", s_cnt, (r + 1 < CNT_MAX) ? r + 1 : CNT_MAX);
        end

        // Random traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) host_req = ~host_req;
            scrub_en  = ($urandom_range(0, 3) != 0);
            eng_len   = int'($urandom_range(1, 10));
            eng_never = ($urandom_range(0, 15) == 0) ? 1 : 0;
            tick_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
